// File: rtl/mouse_pio_sequencer_if.sv
// Packet input and Avalon-MM PIO write bus for mouse_pio_sequencer.
// master = sequencer side, slave = packet source / PIO side.
interface mouse_pio_sequencer_if;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [8:0]  pkt_dx;
  logic [8:0]  pkt_dy;
  logic [2:0]  pkt_buttons;
  logic [1:0]  pio_address;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        pio_cs_x;
  logic        pio_cs_y;
  logic        pio_cs_btn;

  modport master (
    input  pkt_valid, pkt_dx, pkt_dy, pkt_buttons,
    output pkt_ready, pio_address, pio_write_n, pio_writedata,
    output pio_cs_x, pio_cs_y, pio_cs_btn
  );

  modport slave (
    output pkt_valid, pkt_dx, pkt_dy, pkt_buttons,
    input  pkt_ready, pio_address, pio_write_n, pio_writedata,
    input  pio_cs_x, pio_cs_y, pio_cs_btn
  );
endinterface

// File: rtl/mouse_pio_sequencer.sv
// Mouse packet -> clamped absolute cursor, written to the X/Y PIO slaves.
// Optional button PIO write enabled by defining MOUSE_BTN_PIO_EN.
//
// state  | meaning
// INIT   | after reset, push the reset position to the PIOs
// IDLE   | wait for a packet or a recenter request
// CALC   | add deltas, clamp, register new position
// WR_X   | Avalon write of pos_x to the X PIO
// WR_Y   | Avalon write of pos_y to the Y PIO
// WR_BTN | Avalon write of the button state (feature only)
module mouse_pio_sequencer #(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  recenter_i,
  mouse_pio_sequencer_if.master bus,
  output logic [15:0]           pos_x_o,
  output logic [15:0]           pos_y_o,
  output logic                  busy_o
);

`ifdef MOUSE_BTN_PIO_EN
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_CALC, ST_WR_X, ST_WR_Y, ST_WR_BTN} state_t;
`else
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_CALC, ST_WR_X, ST_WR_Y} state_t;
`endif

  state_t       state_q;
  logic [15:0]  pos_x_q, pos_y_q;
  logic [15:0]  pos_x_d, pos_y_d;
  logic [8:0]   dx_q, dy_q;
  logic [2:0]   btn_q;
  logic         rc_pend_q;
  logic         cs_x_q, cs_y_q, cs_btn_q, wr_n_q;
  logic [31:0]  wdata_q;
  logic         pkt_ready;
  logic signed [17:0] nx_s, ny_s;

  // Signed 18-bit arithmetic so both underflow and overflow are visible.
  always_comb begin
    nx_s = $signed({2'b00, pos_x_q}) + $signed({{9{dx_q[8]}}, dx_q});
    ny_s = $signed({2'b00, pos_y_q}) - $signed({{9{dy_q[8]}}, dy_q});
    pos_x_d = nx_s[15:0];
    pos_y_d = ny_s[15:0];
    if (nx_s[17])                      pos_x_d = 16'd0;
    else if (nx_s[16:0] > 17'(X_MAX))  pos_x_d = 16'(X_MAX);
    if (ny_s[17])                      pos_y_d = 16'd0;
    else if (ny_s[16:0] > 17'(Y_MAX))  pos_y_d = 16'(Y_MAX);
  end

  assign pkt_ready = (state_q == ST_IDLE) && !recenter_i && !rc_pend_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_INIT;
      pos_x_q   <= 16'(X_INIT);
      pos_y_q   <= 16'(Y_INIT);
      dx_q      <= '0;
      dy_q      <= '0;
      btn_q     <= '0;
      rc_pend_q <= 1'b0;
      cs_x_q    <= 1'b0;
      cs_y_q    <= 1'b0;
      cs_btn_q  <= 1'b0;
      wr_n_q    <= 1'b1;
      wdata_q   <= '0;
    end else begin
      cs_x_q   <= 1'b0;
      cs_y_q   <= 1'b0;
      cs_btn_q <= 1'b0;
      wr_n_q   <= 1'b1;
      wdata_q  <= '0;
      if (recenter_i && state_q != ST_IDLE) rc_pend_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          state_q <= ST_WR_X;
          cs_x_q  <= 1'b1;
          wr_n_q  <= 1'b0;
          wdata_q <= {16'b0, pos_x_q};
        end
        ST_IDLE: begin
          if (recenter_i || rc_pend_q) begin
            pos_x_q   <= 16'(X_INIT);
            pos_y_q   <= 16'(Y_INIT);
            rc_pend_q <= 1'b0;
            state_q   <= ST_WR_X;
            cs_x_q    <= 1'b1;
            wr_n_q    <= 1'b0;
            wdata_q   <= {16'b0, 16'(X_INIT)};
          end else if (bus.pkt_valid && pkt_ready) begin
            dx_q    <= bus.pkt_dx;
            dy_q    <= bus.pkt_dy;
`ifdef MOUSE_BTN_PIO_EN
            btn_q   <= bus.pkt_buttons;
`endif
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          pos_x_q <= pos_x_d;
          pos_y_q <= pos_y_d;
          state_q <= ST_WR_X;
          cs_x_q  <= 1'b1;
          wr_n_q  <= 1'b0;
          wdata_q <= {16'b0, pos_x_d};
        end
        ST_WR_X: begin
          state_q <= ST_WR_Y;
          cs_y_q  <= 1'b1;
          wr_n_q  <= 1'b0;
          wdata_q <= {16'b0, pos_y_q};
        end
`ifdef MOUSE_BTN_PIO_EN
        ST_WR_Y: begin
          state_q  <= ST_WR_BTN;
          cs_btn_q <= 1'b1;
          wr_n_q   <= 1'b0;
          wdata_q  <= {29'b0, btn_q};
        end
        ST_WR_BTN: state_q <= ST_IDLE;
`else
        ST_WR_Y: state_q <= ST_IDLE;
`endif
        default: state_q <= ST_INIT;
      endcase
    end
  end

`ifndef MOUSE_BTN_PIO_EN
  logic unused_btn;
  assign unused_btn = ^{bus.pkt_buttons, btn_q};
`endif

  assign bus.pkt_ready     = pkt_ready;
  assign bus.pio_address   = 2'b00;
  assign bus.pio_write_n   = wr_n_q;
  assign bus.pio_writedata = wdata_q;
  assign bus.pio_cs_x      = cs_x_q;
  assign bus.pio_cs_y      = cs_y_q;
  assign bus.pio_cs_btn    = cs_btn_q;
  assign pos_x_o           = pos_x_q;
  assign pos_y_o           = pos_y_q;
  assign busy_o            = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mouse_pio_sequencer.sv
// Directed self-checking bench for mouse_pio_sequencer (honours MOUSE_BTN_PIO_EN).
module tb_mouse_pio_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        recenter;
  logic [15:0] pos_x, pos_y;
  logic        busy;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  last_btn = 3'b000;

  mouse_pio_sequencer_if bus();

  mouse_pio_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .recenter_i (recenter),
    .bus        (bus),
    .pos_x_o    (pos_x),
    .pos_y_o    (pos_y),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  localparam logic [35:0] IDLE_BUS = {4'b0001, 32'h0};

  function automatic logic [35:0] pio_bus();
    return {bus.pio_cs_x, bus.pio_cs_y, bus.pio_cs_btn, bus.pio_write_n, bus.pio_writedata};
  endfunction
  function automatic logic [35:0] xw(input logic [15:0] v);
    return {4'b1000, 16'h0, v};
  endfunction
  function automatic logic [35:0] yw(input logic [15:0] v);
    return {4'b0100, 16'h0, v};
  endfunction
  function automatic logic [35:0] bw(input logic [2:0] b);
    return {4'b0010, 29'h0, b};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; recenter = 1'b0;
    bus.pkt_valid = 1'b0; bus.pkt_dx = '0; bus.pkt_dy = '0; bus.pkt_buttons = '0;
    tick(); tick();
    n_cmp++; if (pio_bus() !== IDLE_BUS) begin n_bad++; $display("FAIL rst_bus act=%h exp=%h", pio_bus(), IDLE_BUS); end
    n_cmp++; if ({pos_x, pos_y} !== {16'd320, 16'd240}) begin n_bad++; $display("FAIL rst_pos act=%0d,%0d exp=320,240", pos_x, pos_y); end
    n_cmp++; if (bus.pkt_ready !== 1'b0 || bus.pio_address !== 2'b00) begin n_bad++; $display("FAIL rst_ready_addr act=%b,%b exp=0,00", bus.pkt_ready, bus.pio_address); end
    reset = 1'b0;
    tick();
    n_cmp++; if (pio_bus() !== xw(16'd320)) begin n_bad++; $display("FAIL init_x act=%h exp=%h", pio_bus(), xw(16'd320)); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL init_busy act=%b exp=1", busy); end
    tick();
    n_cmp++; if (pio_bus() !== yw(16'd240)) begin n_bad++; $display("FAIL init_y act=%h exp=%h", pio_bus(), yw(16'd240)); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
    n_cmp++; if (pio_bus() !== bw(3'b000)) begin n_bad++; $display("FAIL init_btn act=%h exp=%h", pio_bus(), bw(3'b000)); end
`endif
    tick();
    n_cmp++; if (busy !== 1'b0 || bus.pkt_ready !== 1'b1 || pio_bus() !== IDLE_BUS) begin
      n_bad++; $display("FAIL init_idle act=busy%b rdy%b bus%h exp=busy0 rdy1 bus%h", busy, bus.pkt_ready, pio_bus(), IDLE_BUS);
    end
  endtask

  task automatic test_move(input string nm, input logic [8:0] dx, input logic [8:0] dy,
                           input logic [2:0] btn, input logic [15:0] ex, input logic [15:0] ey);
    bus.pkt_valid = 1'b1; bus.pkt_dx = dx; bus.pkt_dy = dy; bus.pkt_buttons = btn;
    #1;
    n_cmp++; if (bus.pkt_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready_T act=%b exp=1", nm, bus.pkt_ready); end
    tick();
    bus.pkt_valid = 1'b0;
    n_cmp++; if (bus.pkt_ready !== 1'b0 || pio_bus() !== IDLE_BUS) begin n_bad++; $display("FAIL %s_calc act=rdy%b bus%h exp=rdy0 bus%h", nm, bus.pkt_ready, pio_bus(), IDLE_BUS); end
    tick();
    n_cmp++; if (pio_bus() !== xw(ex) || bus.pkt_ready !== 1'b0) begin n_bad++; $display("FAIL %s_x act=%h rdy%b exp=%h rdy0", nm, pio_bus(), bus.pkt_ready, xw(ex)); end
    tick();
    n_cmp++; if (pio_bus() !== yw(ey) || bus.pkt_ready !== 1'b0) begin n_bad++; $display("FAIL %s_y act=%h rdy%b exp=%h rdy0", nm, pio_bus(), bus.pkt_ready, yw(ey)); end
    n_cmp++; if ({pos_x, pos_y} !== {ex, ey}) begin n_bad++; $display("FAIL %s_pos act=%0d,%0d exp=%0d,%0d", nm, pos_x, pos_y, ex, ey); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
    n_cmp++; if (pio_bus() !== bw(btn)) begin n_bad++; $display("FAIL %s_btn act=%h exp=%h", nm, pio_bus(), bw(btn)); end
`endif
    last_btn = btn;
    tick();
    n_cmp++; if (bus.pkt_ready !== 1'b1 || pio_bus() !== IDLE_BUS) begin n_bad++; $display("FAIL %s_done act=rdy%b bus%h exp=rdy1 bus%h", nm, bus.pkt_ready, pio_bus(), IDLE_BUS); end
  endtask

  task automatic test_recenter_priority();
    recenter = 1'b1; bus.pkt_valid = 1'b1; bus.pkt_dx = 9'd1; bus.pkt_dy = 9'd1; bus.pkt_buttons = 3'b111;
    #1;
    n_cmp++; if (bus.pkt_ready !== 1'b0) begin n_bad++; $display("FAIL prio_ready act=%b exp=0", bus.pkt_ready); end
    tick();
    recenter = 1'b0; bus.pkt_valid = 1'b0;
    n_cmp++; if (pio_bus() !== xw(16'd320)) begin n_bad++; $display("FAIL prio_x act=%h exp=%h", pio_bus(), xw(16'd320)); end
    tick();
    n_cmp++; if (pio_bus() !== yw(16'd240)) begin n_bad++; $display("FAIL prio_y act=%h exp=%h", pio_bus(), yw(16'd240)); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
    n_cmp++; if (pio_bus() !== bw(last_btn)) begin n_bad++; $display("FAIL prio_btn act=%h exp=%h", pio_bus(), bw(last_btn)); end
`endif
    tick();
    n_cmp++; if ({pos_x, pos_y} !== {16'd320, 16'd240} || bus.pkt_ready !== 1'b1) begin
      n_bad++; $display("FAIL prio_done act=%0d,%0d rdy%b exp=320,240 rdy1", pos_x, pos_y, bus.pkt_ready);
    end
  endtask

  task automatic test_recenter_pending();
    bus.pkt_valid = 1'b1; bus.pkt_dx = 9'd4; bus.pkt_dy = 9'h1FC; bus.pkt_buttons = 3'b010;
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    recenter = 1'b1;
    n_cmp++; if (pio_bus() !== xw(16'd324)) begin n_bad++; $display("FAIL pend_x act=%h exp=%h", pio_bus(), xw(16'd324)); end
    tick();
    recenter = 1'b0;
    n_cmp++; if (pio_bus() !== yw(16'd244)) begin n_bad++; $display("FAIL pend_y act=%h exp=%h", pio_bus(), yw(16'd244)); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
    n_cmp++; if (pio_bus() !== bw(3'b010)) begin n_bad++; $display("FAIL pend_btn act=%h exp=%h", pio_bus(), bw(3'b010)); end
`endif
    last_btn = 3'b010;
    tick();
    n_cmp++; if (busy !== 1'b0 || bus.pkt_ready !== 1'b0) begin n_bad++; $display("FAIL pend_idle act=busy%b rdy%b exp=busy0 rdy0", busy, bus.pkt_ready); end
    tick();
    n_cmp++; if (pio_bus() !== xw(16'd320)) begin n_bad++; $display("FAIL pend_rx act=%h exp=%h", pio_bus(), xw(16'd320)); end
    tick();
    n_cmp++; if (pio_bus() !== yw(16'd240)) begin n_bad++; $display("FAIL pend_ry act=%h exp=%h", pio_bus(), yw(16'd240)); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
`endif
    tick();
    n_cmp++; if (bus.pkt_ready !== 1'b1) begin n_bad++; $display("FAIL pend_done act=%b exp=1", bus.pkt_ready); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  dxs [3] = '{9'd1, 9'h1FE, 9'd0};
    logic [8:0]  dys [3] = '{9'd1, 9'd0, 9'h1FF};
    logic [15:0] exs [3] = '{16'd321, 16'd319, 16'd319};
    logic [15:0] eys [3] = '{16'd239, 16'd239, 16'd240};
    int n_hs = 0;
    int n_post;
`ifdef MOUSE_BTN_PIO_EN
    n_post = 4;
`else
    n_post = 3;
`endif
    for (int p = 0; p < 3; p++) begin
      bus.pkt_valid = 1'b1; bus.pkt_dx = dxs[p]; bus.pkt_dy = dys[p]; bus.pkt_buttons = 3'(p + 1);
      #1;
      if (bus.pkt_ready) n_hs++;
      for (int c = 1; c <= n_post; c++) begin
        tick();
        if (bus.pkt_ready) n_hs++;
        if (c == 2) begin
          n_cmp++; if (pio_bus() !== xw(exs[p])) begin n_bad++; $display("FAIL b2b%0d_x act=%h exp=%h", p, pio_bus(), xw(exs[p])); end
        end else if (c == 3) begin
          n_cmp++; if (pio_bus() !== yw(eys[p])) begin n_bad++; $display("FAIL b2b%0d_y act=%h exp=%h", p, pio_bus(), yw(eys[p])); end
        end else if (c == 4) begin
          n_cmp++; if (pio_bus() !== bw(3'(p + 1))) begin n_bad++; $display("FAIL b2b%0d_btn act=%h exp=%h", p, pio_bus(), bw(3'(p + 1))); end
        end
      end
      tick();
    end
    bus.pkt_valid = 1'b0;
    last_btn = 3'd3;
    n_cmp++; if (n_hs !== 3) begin n_bad++; $display("FAIL b2b_handshakes act=%0d exp=3", n_hs); end
  endtask

  task automatic test_reset_midwrite();
    bus.pkt_valid = 1'b1; bus.pkt_dx = 9'd5; bus.pkt_dy = 9'd5; bus.pkt_buttons = 3'b001;
    tick();
    bus.pkt_valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (pio_bus() !== yw(16'd235)) begin n_bad++; $display("FAIL mid_y act=%h exp=%h", pio_bus(), yw(16'd235)); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (pio_bus() !== IDLE_BUS) begin n_bad++; $display("FAIL mid_drop act=%h exp=%h", pio_bus(), IDLE_BUS); end
    n_cmp++; if ({pos_x, pos_y} !== {16'd320, 16'd240}) begin n_bad++; $display("FAIL mid_pos act=%0d,%0d exp=320,240", pos_x, pos_y); end
    tick();
    n_cmp++; if (pio_bus() !== xw(16'd320)) begin n_bad++; $display("FAIL mid_rx act=%h exp=%h", pio_bus(), xw(16'd320)); end
    tick();
    n_cmp++; if (pio_bus() !== yw(16'd240)) begin n_bad++; $display("FAIL mid_ry act=%h exp=%h", pio_bus(), yw(16'd240)); end
`ifdef MOUSE_BTN_PIO_EN
    tick();
    n_cmp++; if (pio_bus() !== bw(3'b000)) begin n_bad++; $display("FAIL mid_rbtn act=%h exp=%h", pio_bus(), bw(3'b000)); end
`endif
  endtask

  initial begin
    reset = 1'b1; recenter = 1'b0;
    bus.pkt_valid = 1'b0; bus.pkt_dx = '0; bus.pkt_dy = '0; bus.pkt_buttons = '0;
    test_reset();
    test_move("mv_basic",  9'd10,     9'd5,      3'b101, 16'd330, 16'd235);
    test_move("mv_to100",  -9'sd230,  9'd225,    3'b000, 16'd100, 16'd10);
    test_move("mv_under",  9'h100,    9'd100,    3'b011, 16'd0,   16'd0);
    test_move("mv_up1",    9'd255,    -9'sd255,  3'b000, 16'd255, 16'd255);
    test_move("mv_up2",    9'd255,    -9'sd215,  3'b000, 16'd510, 16'd470);
    test_move("mv_up3",    9'd120,    9'd0,      3'b000, 16'd630, 16'd470);
    test_move("mv_over",   9'd255,    -9'sd255,  3'b110, 16'd639, 16'd479);
    test_recenter_priority();
    test_recenter_pending();
    test_back_to_back();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mouse_pio_sequencer.md
Name: mouse_pio_sequencer

Overview:
- Converts mouse movement packets (signed dx/dy plus buttons) into an absolute cursor position clamped to the screen.
- Drives Avalon-MM writes into the 16-bit PIO output slaves for mouse X and mouse Y, one write per cycle, in a fixed order.
- Sits between the mouse packet decoder and the PIO slaves, so the NIOS and VGA logic always see a consistent, in-range position.

Parameters:
- X_MAX, 639, largest legal X coordinate (inclusive).
- Y_MAX, 479, largest legal Y coordinate (inclusive).
- X_INIT, 320, X position after reset or recenter.
- Y_INIT, 240, Y position after reset or recenter.

Ports:
- clk  input  1  system clock; one clock domain, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- pkt_valid  input  1  a movement packet is offered.
- pkt_ready  output  1  the packet is accepted when pkt_valid && pkt_ready.
- pkt_dx  input  9  signed two's-complement X delta; positive moves right.
- pkt_dy  input  9  signed two's-complement Y delta; positive moves up.
- pkt_buttons  input  3  button state {middle, right, left}.
- recenter  input  1  single-cycle request to reload X_INIT/Y_INIT.
- pio_address  output  2  Avalon address; always 0.
- pio_write_n  output  1  Avalon write strobe, active low.
- pio_writedata  output  32  {16'b0, value}.
- pio_cs_x  output  1  chipselect for the X PIO.
- pio_cs_y  output  1  chipselect for the Y PIO.
- pio_cs_btn  output  1  chipselect for the button PIO (see Optional Feature).
- pos_x  output  16  current registered X position.
- pos_y  output  16  current registered Y position.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- States: INIT, IDLE, CALC, WR_X, WR_Y, WR_BTN (WR_BTN exists only with the feature).
- Reset, applied in any state: next state is INIT.
  - pos_x=X_INIT, pos_y=Y_INIT, buttons register=0, recenter_pend=0.
  - All chipselects 0, pio_write_n=1, pio_writedata=0, pkt_ready=0.
  - A write in progress is abandoned with no partial strobe: the chipselect drops in the first cycle reset is sampled high.
- INIT: go to WR_X, so the PIOs receive the reset position after every reset.
- IDLE:
  - pkt_ready = (state==IDLE) && !recenter && !recenter_pend (combinational).
  - If recenter or recenter_pend is set: load X_INIT/Y_INIT, clear recenter_pend, go to WR_X. Recenter has priority over a simultaneous pkt_valid, and that packet is not accepted.
  - Else, on a packet handshake: capture dx, dy and buttons, go to CALC.
- CALC, one cycle:
  - nx = pos_x + sext(dx), evaluated as a signed 18-bit value.
  - ny = pos_y - sext(dy), because screen Y grows downward.
  - Clamp each result: below 0 gives 0; above X_MAX (or Y_MAX) gives the max.
  - Register the clamped values into pos_x/pos_y, go to WR_X.
- WR_X: pio_cs_x=1, pio_write_n=0, pio_writedata={16'b0,pos_x}; next state WR_Y.
- WR_Y: same as WR_X using pio_cs_y and pos_y; next state WR_BTN if enabled, else IDLE.
- Outside the WR_* states: all chipselects 0, pio_write_n=1, pio_writedata=0.
- Only one chipselect is ever asserted in any cycle.
- The PIO slaves have zero wait states, so each write completes in its own cycle.
- recenter asserted outside IDLE sets recenter_pend. It is serviced on the first IDLE cycle, and multiple pulses collapse to one.
- Latency, with a handshake at cycle T:
  - Without the feature: X write at T+2, Y write at T+3, pkt_ready high again at T+4.
  - With the feature: button write at T+4, pkt_ready high again at T+5.
- Recenter in IDLE at cycle T: X write at T+1, Y write at T+2.
- pos_x/pos_y change only on the clock edge ending CALC, a recenter load, or reset.

Optional Feature:
- Macro: MOUSE_BTN_PIO_EN.
- Defined: WR_BTN follows WR_Y and writes {29'b0, buttons} with pio_cs_btn=1. INIT also writes buttons=0.
- Not defined: no WR_BTN state, pio_cs_btn tied 0, pkt_buttons ignored, WR_Y returns to IDLE.

Test Plan:
- Reset for 2 cycles, then release: X write of 320, then Y write of 240, on consecutive cycles; pos_x=320, pos_y=240; busy falls afterwards.
- From (320,240), packet dx=+10, dy=+5 accepted at T: X write 330 at T+2, Y write 235 at T+3; pkt_ready=0 during T+1..T+3.
- From (100,10), dx=-256, dy=+100 → 0 and 0. From (630,470), dx=+255, dy=-255 → 639 and 479.
- Recenter and pkt_valid in the same IDLE cycle: packet not accepted, writes of 320 and 240 follow. A recenter pulse during WR_X is serviced immediately after the current sequence.
- pkt_valid held high for 3 back-to-back packets: exactly 3 handshakes, each followed by an X/Y write pair with no overlap; with MOUSE_BTN_PIO_EN, each pair is followed by a button write.
- Reset asserted during WR_Y: pio_cs_y=0 the next cycle, then the INIT sequence rewrites 320/240.
